load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, bus-wait limit in cycles; legal range 2..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  EX/MEM holds a memory instruction.
REQ-006 i_read / i_write  input  1 each  load / store; never both set.
REQ-007 i_funct3  input  3  RISC-V size and sign code.
REQ-008 i_addr  input  XLEN  byte address.
REQ-009 i_wdata  input  XLEN  store data, right-aligned.
REQ-010 o_stall  output  1  freeze the IF..EX/MEM stages.
REQ-011 o_rdata  output  XLEN  extended load result.
REQ-012 o_rdata_valid  output  1  o_rdata is valid for this cycle.
REQ-013 o_fault  output  1  misaligned or illegal access.
REQ-014 o_bus_error  output  1  bus timeout pulse.
REQ-015 o_mem_req, o_mem_we  output  1 each  bus request and write flag.
REQ-016 o_mem_addr  output  XLEN  address aligned to XLEN/8 bytes.
REQ-017 o_mem_wdata  output  XLEN  lane-replicated store data.
REQ-018 o_mem_be  output  XLEN/8  byte enables.
REQ-019 i_mem_ack  input  1  bus completion.
REQ-020 i_mem_rdata  input  XLEN  bus read word; valid when i_mem_ack is high.

Function
REQ-021 The FSM SHALL have three states.
- IDLE to BUSY on an accepted access.
- BUSY to DONE when i_mem_ack is sampled high (or on timeout).
- DONE to IDLE unconditionally.
REQ-022 Accepted access: IDLE, i_valid, (i_read|i_write), legal funct3, aligned address; the unit SHALL register address, byte enables, wdata, funct3 and the write flag.
REQ-023 o_stall SHALL be high for an accepted access in IDLE (combinational) and throughout BUSY; it SHALL be low in DONE.
REQ-024 o_mem_req SHALL be high only in BUSY, with o_mem_addr/o_mem_we/o_mem_be/o_mem_wdata held stable until ack.
REQ-025 Minimum latency SHALL be 3 cycles: accept in c0, ack in c1, DONE in c2.
REQ-026 In DONE, o_rdata_valid SHALL be 1 for loads and 0 for stores.
- o_rdata holds the extended data registered on ack.
- No new access is accepted in DONE.
REQ-027 Load extension: LB/LH/LW(/LD) sign-extend, LBU/LHU(/LWU) zero-extend, with the lane selected by the low address bits.
REQ-028 Store byte enables and data:
- SB: enable = 1 << addr low bits, byte replicated across all lanes.
- SH: two enables, halfword replicated.
- SW: four enables.
- SD (XLEN=64 only): all enables.
REQ-029 Faults: a half access with addr[0]!=0, a word access with addr[1:0]!=0, a double access with addr[2:0]!=0, or illegal funct3 (LD/LWU/SD when XLEN=32) SHALL raise o_fault combinationally while i_valid is high; no bus request and no stall.
REQ-030 i_mem_ack outside BUSY SHALL be ignored.
REQ-031 o_rdata SHALL hold its value outside DONE.

Reset
REQ-032 rstn low SHALL force IDLE immediately, including mid-BUSY, and clear the timeout counter.
REQ-033 Reset values: o_mem_req=0, o_stall=0, o_rdata=0, o_rdata_valid=0, o_bus_error=0, o_mem_be=0.

Configuration
REQ-034 Macro LSU_TIMEOUT_EN.
- Defined: a counter cleared on entry to BUSY, incremented per BUSY cycle without ack. On reaching TIMEOUT_CYCLES the unit SHALL drop o_mem_req, enter DONE with o_bus_error=1 for that single cycle and o_rdata=0.
- Undefined: BUSY waits indefinitely, no counter logic is present, and o_bus_error is tied to 0.

Structure
REQ-035 Package lsu_pkg SHALL hold:
- the state enum {LSU_IDLE, LSU_BUSY, LSU_DONE};
- funct3 localparams (F3_LB..F3_LWU);
- the access-size enum.
REQ-036 Sub-module lsu_align (combinational) SHALL generate byte enables, store replication and load extension; the FSM, registers and counter stay in load_store_unit.

Verification
REQ-037 LW at 0x100, ack on first BUSY cycle, rdata=0x8000_00F0 -> o_stall high 2 cycles, DONE in cycle 2, o_rdata=0x8000_00F0.
REQ-038 LB at 0x103, rdata=0x80xx_xxxx -> o_rdata=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-039 SH at 0x202, wdata=0x1234 -> o_mem_addr=0x200, o_mem_be=4'b1100, o_mem_wdata=0x1234_1234, o_mem_we=1.
REQ-040 LW at 0x101 -> o_fault=1, o_mem_req never high, o_stall=0.
REQ-041 rstn low during BUSY with ack delayed 5 cycles -> o_mem_req falls asynchronously, IDLE; a later ack is ignored.
REQ-042 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> o_bus_error pulses for 1 cycle after 4 BUSY cycles and o_rdata=0; without the macro, o_stall stays high indefinitely.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes and RISC-V funct3 codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUSY,
        LSU_DONE
    } lsu_state_e;

    // Encoding matches funct3[1:0] so the size falls straight out of the opcode.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    function automatic lsu_size_e f3_size(input logic [2:0] funct3);
        return lsu_size_e'(funct3[1:0]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request legality, store byte enables / replication, load lane select and extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                   st_funct3,
    input  logic                         st_write,
    input  logic [2:0]                   st_addr_lo,
    input  logic [XLEN-1:0]              st_wdata,
    input  logic [2:0]                   ld_funct3,
    input  logic [$clog2(XLEN/8)-1:0]    ld_off,
    input  logic [XLEN-1:0]              ld_rdata,
    output logic [XLEN/8-1:0]            st_be,
    output logic [XLEN-1:0]              st_data,
    output logic [XLEN-1:0]              ld_data,
    output logic                         st_bad
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_size_e        st_size;
    lsu_size_e        ld_size;
    logic [OFFW-1:0]  st_off;
    logic [NB-1:0]    be_base;
    logic             illegal;
    logic             misaligned;
    logic             ld_sext;
    logic [XLEN-1:0]  shifted;

    assign st_size = f3_size(st_funct3);
    assign ld_size = f3_size(ld_funct3);
    assign st_off  = st_addr_lo[OFFW-1:0];
    assign ld_sext = ~ld_funct3[2];

    // Stores have no unsigned forms; doubles and LWU only exist on a 64-bit datapath.
    always_comb begin
        illegal = (st_funct3 == 3'b111) || (st_write && st_funct3[2]) ||
                  ((XLEN == 32) && ((st_funct3[1:0] == 2'b11) || (st_funct3 == F3_LWU)));
        case (st_size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = st_addr_lo[0];
            SZ_W:    misaligned = |st_addr_lo[1:0];
            default: misaligned = |st_addr_lo[2:0];
        endcase
        st_bad = illegal | misaligned;
    end

    always_comb begin
        be_base = '0;
        case (st_size)
            SZ_B:    be_base[0]   = 1'b1;
            SZ_H:    be_base[1:0] = 2'b11;
            SZ_W:    be_base[3:0] = 4'hF;
            default: be_base      = '1;
        endcase
        st_be = be_base << st_off;
    end

    always_comb begin
        case (st_size)
            SZ_B:    st_data = {(XLEN/8){st_wdata[7:0]}};
            SZ_H:    st_data = {(XLEN/16){st_wdata[15:0]}};
            SZ_W:    st_data = {(XLEN/32){st_wdata[31:0]}};
            default: st_data = st_wdata;
        endcase
    end

    assign shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        case (ld_size)
            SZ_B:    ld_data = ld_sext ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
            SZ_H:    ld_data = ld_sext ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
            SZ_W:    ld_data = ld_sext ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the EX/MEM stage and a request/ack memory bus.
// Optional bus-wait timeout is compiled in with `define LSU_TIMEOUT_EN.
//
// state    | meaning
// LSU_IDLE | waiting for a legal, aligned access; accepting one stalls the pipe
// LSU_BUSY | bus request outstanding, request fields held stable
// LSU_DONE | result cycle: load data (or bus error) presented, pipe released
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_valid,
    input  logic                 i_read,
    input  logic                 i_write,
    input  logic [2:0]           i_funct3,
    input  logic [XLEN-1:0]      i_addr,
    input  logic [XLEN-1:0]      i_wdata,
    output logic                 o_stall,
    output logic [XLEN-1:0]      o_rdata,
    output logic                 o_rdata_valid,
    output logic                 o_fault,
    output logic                 o_bus_error,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [XLEN-1:0]      o_mem_addr,
    output logic [XLEN-1:0]      o_mem_wdata,
    output logic [XLEN/8-1:0]    o_mem_be,
    input  logic                 i_mem_ack,
    input  logic [XLEN-1:0]      i_mem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_e        state_q;
    lsu_state_e        state_d;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic [NB-1:0]     be_q;
    logic [2:0]        funct3_q;
    logic              we_q;

    logic              access;
    logic              req_bad;
    logic              accept;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [NB-1:0]     st_be;
    logic [XLEN-1:0]   st_data;
    logic [XLEN-1:0]   ld_data;

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_funct3  (i_funct3),
        .st_write   (i_write),
        .st_addr_lo (i_addr[2:0]),
        .st_wdata   (i_wdata),
        .ld_funct3  (funct3_q),
        .ld_off     (addr_q[OFFW-1:0]),
        .ld_rdata   (i_mem_rdata),
        .st_be      (st_be),
        .st_data    (st_data),
        .ld_data    (ld_data),
        .st_bad     (req_bad)
    );

    assign access  = i_valid & (i_read | i_write);
    assign o_fault = access & req_bad;
    assign busy    = (state_q == LSU_BUSY);
    assign done    = (state_q == LSU_DONE);
    assign accept  = (state_q == LSU_IDLE) & access & ~req_bad;

`ifdef LSU_TIMEOUT_EN
    logic [7:0] wait_cnt_q;
    logic       bus_err_q;

    assign timeout = busy & ~i_mem_ack & (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            if (accept)
                wait_cnt_q <= '0;
            else if (busy && !i_mem_ack)
                wait_cnt_q <= wait_cnt_q + 8'd1;
            // timeout is only ever high on the last BUSY cycle, so this lands on DONE alone
            bus_err_q <= timeout;
        end
    end

    assign o_bus_error = bus_err_q;
`else
    assign timeout     = 1'b0;
    assign o_bus_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= LSU_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (accept) state_d = LSU_BUSY;
            LSU_BUSY: if (i_mem_ack || timeout) state_d = LSU_DONE;
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        o_stall       = accept | busy;
        o_mem_req     = busy;
        o_mem_we      = busy & we_q;
        o_rdata_valid = done & ~we_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                addr_q   <= i_addr;
                wdata_q  <= st_data;
                be_q     <= st_be;
                funct3_q <= i_funct3;
                we_q     <= i_write;
            end
            if (busy && i_mem_ack && !we_q)
                rdata_q <= ld_data;
            else if (timeout)
                rdata_q <= '0;
        end
    end

    assign o_mem_addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign o_mem_wdata = wdata_q;
    assign o_mem_be    = be_q;
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN=32): directed vector table, corner sequences, random vs. model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid, i_read, i_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall, o_rdata_valid, o_fault, o_bus_error;
    logic [31:0] o_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_read(i_read), .i_write(i_write),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall),
        .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_fault(o_fault),
        .o_bus_error(o_bus_error), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_rdata = '0;

    typedef struct {
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        int        delay;
        bit        exp_fault;
        bit [31:0] exp_rdata;
        bit [3:0]  exp_be;
        bit [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: access width in bytes, 0 when the funct3 is not a legal RV32 access.
    function automatic int model_size(input bit wr, input bit [2:0] f3);
        if (wr) return (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
        return (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
    endfunction

    function automatic bit [3:0] model_be(input int sz, input bit [31:0] addr);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic bit [31:0] model_wdata(input int sz, input bit [31:0] wdata);
        bit [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            r = r | (((wdata >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic bit [31:0] model_load(input bit [2:0] f3, input int sz, input bit [31:0] addr,
                                             input bit [31:0] rdata);
        longint raw = longint'((rdata >> (8 * (addr % 4)))) & ((64'd1 << (8 * sz)) - 1);
        if (f3 < 4 && raw >= (64'd1 << (8 * sz - 1)))
            raw = raw - (64'd1 << (8 * sz));
        return 32'(raw);
    endfunction

    task automatic idle_inputs();
        i_valid = 0; i_read = 0; i_write = 0; i_funct3 = 0;
        i_addr = 0; i_wdata = 0; i_mem_ack = 0; i_mem_rdata = 0;
    endtask

    task automatic run_access(input vec_t v, input string tag);
        @(negedge clk);
        i_valid = 1; i_read = !v.wr; i_write = v.wr; i_funct3 = v.f3;
        i_addr = v.addr; i_wdata = v.wdata;
        #1;
        check({tag, ".fault"}, o_fault, v.exp_fault);
        check({tag, ".stall_c0"}, o_stall, !v.exp_fault);
        check({tag, ".req_c0"}, o_mem_req, 0);
        if (v.exp_fault) begin
            @(negedge clk);
            check({tag, ".fault_req"}, o_mem_req, 0);
            check({tag, ".fault_stall"}, o_stall, 0);
            idle_inputs();
            return;
        end
        @(negedge clk);
        check({tag, ".req"}, o_mem_req, 1);
        check({tag, ".addr"}, o_mem_addr, v.addr & 32'hFFFF_FFFC);
        check({tag, ".we"}, o_mem_we, v.wr);
        if (v.wr) begin
            check({tag, ".be"}, o_mem_be, v.exp_be);
            check({tag, ".wdata"}, o_mem_wdata, v.exp_wdata);
        end
        for (int k = 0; k < v.delay; k++) begin
            @(negedge clk);
            check({tag, ".wait_req"}, o_mem_req, 1);
            check({tag, ".wait_stall"}, o_stall, 1);
        end
        i_mem_ack = 1; i_mem_rdata = v.rdata;
        @(negedge clk);
        i_mem_ack = 0; i_mem_rdata = $urandom;
        #1;
        if (!v.wr) last_rdata = v.exp_rdata;
        check({tag, ".done_stall"}, o_stall, 0);
        check({tag, ".done_req"}, o_mem_req, 0);
        check({tag, ".rvalid"}, o_rdata_valid, !v.wr);
        check({tag, ".rdata"}, o_rdata, last_rdata);
        check({tag, ".berr"}, o_bus_error, 0);
        idle_inputs();
        @(negedge clk);
        check({tag, ".idle_rvalid"}, o_rdata_valid, 0);
        check({tag, ".hold_rdata"}, o_rdata, last_rdata);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //           wr f3  addr          wdata          rdata          dly flt exp_rdata      be      exp_wdata
        vecs[0]  = '{0, 2, 32'h100, 32'h0,         32'h8000_00F0, 0, 0, 32'h8000_00F0, 4'h0, 32'h0};
        vecs[1]  = '{0, 0, 32'h103, 32'h0,         32'h8012_3456, 0, 0, 32'hFFFF_FF80, 4'h0, 32'h0};
        vecs[2]  = '{0, 4, 32'h103, 32'h0,         32'h8012_3456, 1, 0, 32'h0000_0080, 4'h0, 32'h0};
        vecs[3]  = '{1, 1, 32'h202, 32'h1234,      32'h0,         0, 0, 32'h0,         4'hC, 32'h1234_1234};
        vecs[4]  = '{0, 2, 32'h101, 32'h0,         32'h0,         0, 1, 32'h0,         4'h0, 32'h0};
        vecs[5]  = '{0, 1, 32'h102, 32'h0,         32'h8001_7FFF, 0, 0, 32'hFFFF_8001, 4'h0, 32'h0};
        vecs[6]  = '{0, 5, 32'h102, 32'h0,         32'h8001_7FFF, 2, 0, 32'h0000_8001, 4'h0, 32'h0};
        vecs[7]  = '{1, 0, 32'h301, 32'h55AB,      32'h0,         2, 0, 32'h0,         4'h2, 32'hABAB_ABAB};
        vecs[8]  = '{1, 2, 32'h404, 32'hDEAD_BEEF, 32'h0,         1, 0, 32'h0,         4'hF, 32'hDEAD_BEEF};
        vecs[9]  = '{0, 3, 32'h000, 32'h0,         32'h0,         0, 1, 32'h0,         4'h0, 32'h0};
        vecs[10] = '{1, 4, 32'h000, 32'h0,         32'h0,         0, 1, 32'h0,         4'h0, 32'h0};
        vecs[11] = '{1, 1, 32'h203, 32'h0,         32'h0,         0, 1, 32'h0,         4'h0, 32'h0};
        vecs[12] = '{0, 0, 32'h101, 32'h0,         32'h0000_7F00, 0, 0, 32'h0000_007F, 4'h0, 32'h0};

        idle_inputs();
        rstn = 0;
        #12;
        check("rst.req", o_mem_req, 0);
        check("rst.stall", o_stall, 0);
        check("rst.rdata", o_rdata, 0);
        check("rst.rvalid", o_rdata_valid, 0);
        check("rst.berr", o_bus_error, 0);
        check("rst.be", o_mem_be, 0);
        @(negedge clk);
        rstn = 1;

        for (int i = 0; i < 13; i++)
            run_access(vecs[i], $sformatf("vec%0d", i));

        // Reset while a load waits on a slow bus, then a stray ack arrives.
        @(negedge clk);
        i_valid = 1; i_read = 1; i_funct3 = 3'd2; i_addr = 32'h500;
        repeat (3) @(negedge clk);
        check("rstbusy.req_before", o_mem_req, 1);
        #1;
        rstn = 0; i_valid = 0; i_read = 0;
        #1;
        check("rstbusy.req_async", o_mem_req, 0);
        check("rstbusy.stall", o_stall, 0);
        check("rstbusy.rdata", o_rdata, 0);
        last_rdata = '0;
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        i_mem_ack = 1; i_mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        i_mem_ack = 0;
        check("strayack.req", o_mem_req, 0);
        check("strayack.stall", o_stall, 0);
        check("strayack.rvalid", o_rdata_valid, 0);
        @(negedge clk);
        check("strayack.rdata", o_rdata, 0);

        for (int i = 0; i < 40; i++) begin
            int sz;
            v.wr    = 1'($urandom_range(0, 1));
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom & 32'h0000_FFFF;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.delay = $urandom_range(0, 3);
            sz = model_size(v.wr, v.f3);
            v.exp_fault = (sz == 0) || (v.addr % sz != 0);
            v.exp_rdata = v.exp_fault ? 32'h0 : model_load(v.f3, sz, v.addr, v.rdata);
            v.exp_be    = v.exp_fault ? 4'h0  : model_be(sz, v.addr);
            v.exp_wdata = v.exp_fault ? 32'h0 : model_wdata(sz, v.wdata);
            run_access(v, $sformatf("rnd%0d", i));
        end

        // Load that never gets an ack.
        @(negedge clk);
        i_valid = 1; i_read = 1; i_funct3 = 3'd2; i_addr = 32'h600;
`ifdef LSU_TIMEOUT_EN
        repeat (4) @(negedge clk);
        check("tmo.req_last", o_mem_req, 1);
        @(negedge clk);
        check("tmo.berr", o_bus_error, 1);
        check("tmo.req", o_mem_req, 0);
        check("tmo.rdata", o_rdata, 0);
        last_rdata = '0;
        idle_inputs();
        @(negedge clk);
        check("tmo.berr_pulse", o_bus_error, 0);
`else
        repeat (20) @(negedge clk);
        check("noack.stall", o_stall, 1);
        check("noack.req", o_mem_req, 1);
        check("noack.berr", o_bus_error, 0);
        idle_inputs();
        rstn = 0;
        last_rdata = '0;
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        check("noack.recover", o_mem_req, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
